case_7_mul_share_arb: RTL and testbench
=======================================

CASE_7_MUL_SHARE_ARB -- requirements
Module: case_7_mul_share_arb

Interface
REQ-001 The block SHALL provide parameter N_REQ, default 4, meaning the number of requesters sharing one multiplier.
REQ-002 The block SHALL provide parameter DIN0_WIDTH, default 10, meaning the signed operand A width.
REQ-003 The block SHALL provide parameter DIN1_WIDTH, default 10, meaning the signed operand B width.
REQ-004 The block SHALL provide parameter DOUT_WIDTH, default 16, meaning the result width.
REQ-005 The block SHALL provide port ap_clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 The block SHALL provide port ap_rst_n, input, 1, reset; synchronous, active-low.
REQ-007 The block SHALL provide port req_valid, input, N_REQ, with bit i set when requester i presents operands.
REQ-008 The block SHALL provide port req_ready, output, N_REQ, with bit i set when requester i is granted this cycle.
REQ-009 The block SHALL provide port req_din0, input, N_REQ*DIN0_WIDTH, flattened operand A; slice i = requester i.
REQ-010 The block SHALL provide port req_din1, input, N_REQ*DIN1_WIDTH, flattened operand B; slice i = requester i.
REQ-011 The block SHALL provide port res_valid, output, 1, result register holds a valid result.
REQ-012 The block SHALL provide port res_ready, input, 1, consumer accepts the result.
REQ-013 The block SHALL provide port res_dout, output, DOUT_WIDTH, the product result.
REQ-014 The block SHALL provide port res_id, output, clog2(N_REQ), the index of the requester owning res_dout.
REQ-015 The block SHALL provide port grant_cnt, output, 16, the count of accepted requests.

Function
REQ-016 The block SHALL contain exactly one signed DIN0_WIDTH x DIN1_WIDTH multiplier, combinational, shared by all requesters.
REQ-017 Product arithmetic SHALL be full-precision signed (DIN0_WIDTH+DIN1_WIDTH bits); res_dout = low DOUT_WIDTH bits, wrap, no saturation.
REQ-018 Output stage SHALL be a 2-state FSM: EMPTY (res_valid=0), FULL (res_valid=1).
REQ-019 Accept condition: space = (state==EMPTY) or (res_ready==1); a grant SHALL occur only when space=1 and any req_valid=1.
REQ-020 Arbitration SHALL be round-robin: search starts at index ptr, ascending, wrapping N_REQ-1 -> 0; the first valid requester wins.
REQ-021 On grant to index g, ptr SHALL become (g+1) mod N_REQ next cycle; with no grant, ptr SHALL hold.
REQ-022 req_ready SHALL be one-hot or zero, combinational from req_valid, ptr and space; no requester is ever granted with req_valid=0.
REQ-023 Handshake per requester: transfer when req_valid[i] & req_ready[i]; requester holds valid and operands until transfer.
REQ-024 Latency: result of a transfer in cycle t SHALL appear on res_dout/res_id with res_valid=1 in cycle t+1.
REQ-025 Transitions: EMPTY->FULL on grant; FULL->EMPTY on res_ready with no grant; FULL->FULL (reload) on res_ready with grant; FULL->FULL (hold) on no res_ready.
REQ-026 In FULL with res_ready=0, res_dout and res_id SHALL remain stable and req_ready SHALL be all-zero.
REQ-027 Simultaneous res_ready and grant SHALL sustain one result per cycle with no bubble.
REQ-028 grant_cnt SHALL increment by 1 per transfer, wrapping 0xFFFF -> 0x0000.
REQ-029 In EMPTY, res_dout and res_id SHALL hold their last values; consumers ignore them.

Reset
REQ-030 When ap_rst_n=0 at a clock edge: state=EMPTY, res_valid=0, res_dout=0, res_id=0, ptr=0, grant_cnt=0.
REQ-031 While ap_rst_n=0, req_ready SHALL be all-zero; an in-flight result SHALL be discarded.
REQ-032 First cycle after reset release SHALL give priority to requester 0.

Verification
REQ-033 Single request: req 2 valid, A=100, B=-3, res_ready=1 -> req_ready=0100 same cycle; next cycle res_valid=1, res_dout=0xFED4, res_id=2, grant_cnt=1.
REQ-034 Wrap: A=-512, B=-512 -> res_dout=0x0000; A=511, B=511 -> res_dout=0xFC01.
REQ-035 Fairness: all 4 valid continuously, res_ready=1 -> grants 0,1,2,3,0,... one per cycle, res_valid continuously 1.
REQ-036 Backpressure: res_ready=0 with result held for 5 cycles, req 1 valid -> req_ready=0000, res_dout/res_id stable; res_ready=1 -> req 1 granted same cycle, new result next cycle.
REQ-037 Reset mid-operation: ap_rst_n=0 for one cycle while FULL and req 3 valid -> res_valid=0, grant_cnt=0, ptr=0; after release, valid 0 and 3 -> 0 granted first.
REQ-038 Counter wrap: 65536 transfers -> grant_cnt returns to 0x0000.

Source files
------------

// File: rtl/case_7_mul_share_arb.sv
// case_7_mul_share_arb: round-robin arbiter feeding one shared signed multiplier
// into a single-entry result register with valid/ready handshake.
module case_7_mul_share_arb #(
  parameter int N_REQ      = 4,
  parameter int DIN0_WIDTH = 10,
  parameter int DIN1_WIDTH = 10,
  parameter int DOUT_WIDTH = 16
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst_n,
  input  logic [N_REQ-1:0]              req_valid,
  output logic [N_REQ-1:0]              req_ready,
  input  logic [N_REQ*DIN0_WIDTH-1:0]   req_din0,
  input  logic [N_REQ*DIN1_WIDTH-1:0]   req_din1,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [DOUT_WIDTH-1:0]         res_dout,
  output logic [$clog2(N_REQ)-1:0]      res_id,
  output logic [15:0]                   grant_cnt
);
  localparam int IW = $clog2(N_REQ);
  localparam int PW = DIN0_WIDTH + DIN1_WIDTH;
  typedef enum logic {EMPTY, FULL} state_t;
  state_t                 state_q, state_d;
  logic [IW-1:0]          ptr_q, ptr_d, id_q, id_d, gnt_idx, idx;
  logic [DOUT_WIDTH-1:0]  dout_q, dout_d;
  logic [15:0]            cnt_q, cnt_d;
  logic                   space, gnt;
  logic signed [DIN0_WIDTH-1:0] a;
  logic signed [DIN1_WIDTH-1:0] b;
  logic signed [PW-1:0]         prod;
  assign space = (state_q == EMPTY) || res_ready;
  // First valid requester at or after ptr wins; reset suppresses all grants.
  always_comb begin
    gnt = 1'b0;
    gnt_idx = '0;
    idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = IW'((int'(ptr_q) + k) % N_REQ);
      if (!gnt && space && ap_rst_n && req_valid[idx]) begin
        gnt = 1'b1;
        gnt_idx = idx;
      end
    end
  end
  always_comb begin
    a = req_din0[int'(gnt_idx)*DIN0_WIDTH +: DIN0_WIDTH];
    b = req_din1[int'(gnt_idx)*DIN1_WIDTH +: DIN1_WIDTH];
    prod = a * b;
    req_ready = gnt ? (N_REQ'(1) << gnt_idx) : '0;
    state_d = gnt ? FULL : (res_ready ? EMPTY : state_q);
    dout_d = gnt ? DOUT_WIDTH'(prod) : dout_q;
    id_d = gnt ? gnt_idx : id_q;
    ptr_d = gnt ? ((gnt_idx == IW'(N_REQ-1)) ? '0 : gnt_idx + 1'b1) : ptr_q;
    cnt_d = cnt_q + {15'd0, gnt};
  end
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q <= EMPTY;
      ptr_q <= '0;
      id_q <= '0;
      dout_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      id_q <= id_d;
      dout_q <= dout_d;
      cnt_q <= cnt_d;
    end
  end
  assign res_valid = (state_q == FULL);
  assign res_dout  = dout_q;
  assign res_id    = id_q;
  assign grant_cnt = cnt_q;
endmodule

// File: tb/tb_case_7_mul_share_arb.sv
// tb_case_7_mul_share_arb: scoreboard bench with a queue-based reference model
// of arbitration order, product values and result-register occupancy.
module tb_case_7_mul_share_arb;
  localparam int N = 4, W0 = 10, W1 = 10, WO = 16;
  logic ap_clk = 0, ap_rst_n = 0, res_ready = 0, res_valid;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [N*W0-1:0] req_din0 = '0;
  logic [N*W1-1:0] req_din1 = '0;
  logic [WO-1:0] res_dout;
  logic [1:0] res_id;
  logic [15:0] grant_cnt;
  case_7_mul_share_arb #(.N_REQ(N), .DIN0_WIDTH(W0), .DIN1_WIDTH(W1), .DOUT_WIDTH(WO)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_din0(req_din0), .req_din1(req_din1), .res_valid(res_valid), .res_ready(res_ready),
    .res_dout(res_dout), .res_id(res_id), .grant_cnt(grant_cnt));
  always #5 ap_clk = ~ap_clk;
  typedef struct {int dout; int id;} exp_t;
  exp_t q[$];
  int vectors = 0, errors = 0;
  bit pend_v[N];
  int pend_a[N], pend_b[N];
  bit full = 0;
  int ptr = 0, cnt = 0, mode = 0;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic set_req(int i, int a, int b);
    pend_v[i] = 1; pend_a[i] = a; pend_b[i] = b;
  endtask
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = pend_v[i];
      req_din0[i*W0 +: W0] = W0'(pend_a[i]);
      req_din1[i*W1 +: W1] = W1'(pend_b[i]);
    end
  endtask
  // Reference: who should be served now, and what the result register will hold.
  task automatic eval();
    int g = -1;
    logic [31:0] exp_rdy;
    chk("res_valid", 32'(res_valid), 32'(full));
    chk("grant_cnt", 32'(grant_cnt), 32'(cnt));
    if (ap_rst_n && (!full || res_ready))
      for (int k = 0; k < N; k++)
        if (g < 0 && pend_v[(ptr + k) % N]) g = (ptr + k) % N;
    exp_rdy = (g >= 0) ? (32'd1 << g) : 32'd0;
    chk("req_ready", 32'(req_ready), exp_rdy);
    if (!ap_rst_n) begin
      full = 0; ptr = 0; cnt = 0; q.delete();
    end else if (g >= 0) begin
      q.push_back(exp_t'{(pend_a[g] * pend_b[g]) & 'hFFFF, g});
      ptr = (g + 1) % N;
      cnt = (cnt + 1) % 65536;
      pend_v[g] = 0;
      full = 1;
    end else if (res_ready) full = 0;
  endtask
  task automatic refill();
    for (int i = 0; i < N; i++)
      if (!pend_v[i] && (mode == 1 || (mode == 2 && $urandom_range(0, 1) == 1)))
        set_req(i, int'($urandom_range(0, 1023)) - 512, int'($urandom_range(0, 1023)) - 512);
    if (mode == 2) res_ready = ($urandom_range(0, 3) != 0);
  endtask
  task automatic cycle(int n = 1);
    for (int c = 0; c < n; c++) begin
      drive();
      #1 eval();
      @(posedge ap_clk);
      #1 refill();
    end
  endtask
  task automatic drain();
    mode = 0; res_ready = 1;
    cycle(N + 2);
  endtask
  always @(negedge ap_clk)
    if (ap_rst_n && res_valid) begin
      if (q.size() == 0) begin
        vectors++; errors++;
        $display("FAIL res_extra: got res_valid=1 expected no pending result at %0t", $time);
      end else begin
        chk("res_dout", 32'(res_dout), 32'(q[0].dout));
        chk("res_id", 32'(res_id), 32'(q[0].id));
        if (res_ready) void'(q.pop_front());
      end
    end
  initial begin
    @(posedge ap_clk);
    #1;
    cycle(3);
    ap_rst_n = 1;
    chk("reset_dout", 32'(res_dout), 32'd0);
    chk("reset_id", 32'(res_id), 32'd0);
    res_ready = 1;
    set_req(2, 100, -3);
    chk("single_exp", 32'((100 * -3) & 'hFFFF), 32'h0000FED4);
    cycle(2);
    set_req(0, -512, -512);
    cycle(1);
    set_req(1, 511, 511);
    cycle(2);
    mode = 1;
    for (int i = 0; i < N; i++) set_req(i, int'($urandom_range(0, 1023)) - 512, 7);
    cycle(12);
    drain();
    set_req(0, 17, -9);
    cycle(1);
    res_ready = 0;
    set_req(1, -200, 150);
    cycle(5);
    res_ready = 1;
    cycle(3);
    set_req(0, 3, 4);
    cycle(1);
    res_ready = 0;
    set_req(3, 5, 6);
    cycle(1);
    ap_rst_n = 0;
    cycle(1);
    ap_rst_n = 1;
    chk("midrst_cnt", 32'(grant_cnt), 32'd0);
    chk("midrst_valid", 32'(res_valid), 32'd0);
    res_ready = 1;
    set_req(0, -7, 8);
    cycle(3);
    mode = 2;
    cycle(2000);
    drain();
    ap_rst_n = 0;
    cycle(2);
    ap_rst_n = 1;
    res_ready = 1;
    mode = 1;
    for (int i = 0; i < N; i++) set_req(i, int'($urandom_range(0, 1023)) - 512, 511);
    cycle(65536);
    chk("cnt_wrap", 32'(grant_cnt), 32'd0);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
